rob_ctrl: RTL

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/ooo_pkg.sv | 15 +
 rtl/rob_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared ROB geometry, entry layout and controller state encoding.
package ooo_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  typedef struct packed {
    logic       valid;
    logic       done;
    logic       mispredict;
    logic       wb_en;
    logic [5:0] A_rd;
    logic [6:0] P_rd_new;
    logic [6:0] P_rd_old;
  } rob_entry_t;
  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} rob_state_e;
endpackage

// File: rtl/rob_ctrl.sv
// rob_ctrl: 16-entry reorder buffer with in-order commit and one-cycle mispredict flush.
// Optional perf counters are built only when ROB_PERF_CNT_EN is defined.
module rob_ctrl
  import ooo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [5:0]           alloc_A_rd,
  input  logic [6:0]           alloc_P_rd_new,
  input  logic [6:0]           alloc_P_rd_old,
  input  logic                 alloc_wb_en,
  output logic [ROB_IDX_W-1:0] alloc_idx,
  input  logic                 WB_valid,
  input  logic [ROB_IDX_W-1:0] WB_idx,
  input  logic                 WB_mispredict,
  output logic                 commit_valid,
  output logic                 commit_wb_en,
  output logic [5:0]           commit_A_rd,
  output logic [6:0]           commit_P_rd_new,
  output logic [6:0]           commit_P_rd_old,
  output logic                 recovery
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_commit_cnt,
  output logic [15:0]          perf_flush_cnt
`endif
);
  rob_state_e           r_state;
  rob_entry_t           r_rob [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] r_head;
  logic [ROB_IDX_W-1:0] r_tail;
  logic [ROB_IDX_W:0]   r_count;
  logic                 w_alloc;
  rob_entry_t           w_head_ent;

  always_comb begin
    w_head_ent      = r_rob[r_head];
    alloc_ready     = (r_state == RUN) && (r_count < 5'(ROB_DEPTH));
    alloc_idx       = r_tail;
    w_alloc         = alloc_valid && alloc_ready;
    commit_valid    = (r_state == RUN) && w_head_ent.valid && w_head_ent.done;
    commit_wb_en    = commit_valid && w_head_ent.wb_en;
    commit_A_rd     = w_head_ent.A_rd;
    commit_P_rd_new = w_head_ent.P_rd_new;
    commit_P_rd_old = w_head_ent.P_rd_old;
    recovery        = (r_state == FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rob   <= '{default: '0};
    end else if (r_state == FLUSH) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_rob[i].valid <= 1'b0;
      r_tail  <= r_head;
      r_count <= '0;
      r_state <= RUN;
    end else begin
      if (WB_valid && r_rob[WB_idx].valid) begin
        r_rob[WB_idx].done       <= 1'b1;
        r_rob[WB_idx].mispredict <= WB_mispredict;
      end
      // FLUSH decision uses the registered flag, not a same-cycle WB to the head
      if (commit_valid) begin
        r_rob[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
        if (w_head_ent.mispredict) r_state <= FLUSH;
      end
      if (w_alloc) begin
        r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, wb_en: alloc_wb_en,
                           A_rd: alloc_A_rd, P_rd_new: alloc_P_rd_new, P_rd_old: alloc_P_rd_old};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + 5'(w_alloc) - 5'(commit_valid);
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commit;
  logic [15:0] r_perf_flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_commit <= '0;
      r_perf_flush  <= '0;
    end else begin
      r_perf_commit <= r_perf_commit + 32'(commit_valid);
      r_perf_flush  <= r_perf_flush + 16'(recovery);
    end
  end
  assign perf_commit_cnt = r_perf_commit;
  assign perf_flush_cnt  = r_perf_flush;
`endif
endmodule
